// File: rtl/note_code_source.sv
// Synchronizes and debounces the note-select switches, then publishes a registered
// note code, scale index, note-on flag and a one-cycle note-change strobe.
module note_code_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    output logic [3:0] note_code,
    output logic [2:0] note_index,
    output logic       note_on,
    output logic       note_change
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic [2:0]    index_q, index_d;
    logic          on_q, on_d;
    logic          pend_q, pend_d;
    logic          change_q, change_d;

    logic [3:0]    map_code;
    logic [2:0]    map_index;
    logic          map_on;

    // Mapping of the candidate onto the published outputs; bit 0 low means mute.
    always_comb begin
        map_code  = 4'b0000;
        map_index = 3'd0;
        map_on    = 1'b0;
        if (cand_q[0]) begin
            map_code = cand_q;
            map_on   = 1'b1;
            case (cand_q[3:1])
                3'b000:  map_index = 3'd0;
                3'b001:  map_index = 3'd1;
                3'b010:  map_index = 3'd2;
                3'b100:  map_index = 3'd3;
                3'b011:  map_index = 3'd4;
                3'b101:  map_index = 3'd5;
                3'b110:  map_index = 3'd6;
                default: map_index = 3'd7;
            endcase
        end
    end

    always_comb begin
        sync1_d  = sw_raw;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        code_d   = code_q;
        index_d  = index_q;
        on_d     = on_q;
        pend_d   = 1'b0;
        change_d = pend_q;

        if (sync2_q != cand_q) begin
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = SETTLING;
        end else if (state_q == SETTLING) begin
            if (cnt_q == CNT_LAST) begin
                state_d = STABLE;
                code_d  = map_code;
                index_d = map_index;
                on_d    = map_on;
                // Strobe only when the visible note actually changes.
                pend_d  = ({map_on, map_code} != {on_q, code_q});
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            cand_q   <= 4'b0000;
            cnt_q    <= '0;
            state_q  <= STABLE;
            code_q   <= 4'b0000;
            index_q  <= 3'd0;
            on_q     <= 1'b0;
            pend_q   <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            code_q   <= code_d;
            index_q  <= index_d;
            on_q     <= on_d;
            pend_q   <= pend_d;
            change_q <= change_d;
        end
    end

    assign note_code   = code_q;
    assign note_index  = index_q;
    assign note_on     = on_q;
    assign note_change = change_q;

endmodule
